// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer in front of a word-wide,
// big-endian DataMem that has no byte writes. Requester 0 is the core
// load/store path and requester 1 is the DMA/debug port. Sub-word stores are
// turned into an atomic read-modify-write.
//
// Optional feature macro: DMEM_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins when both are valid
//   undefined -> round-robin (the requester that was not granted last wins)
//
// Handshake: request i is accepted in the cycle where req_valid[i] and
// req_ready[i] are both 1. The requester holds valid/we/be/addr/wdata stable
// until then and cannot cancel afterwards. Each accepted request gets exactly
// one rsp_valid[i] pulse later (load data on rsp_rdata in that same cycle).
// req_ready is asserted only in IDLE, and for at most one requester.
module dmem_arbiter #(
   parameter int N    = 32,
   parameter int NREQ = 2
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ-1:0]           req_we,
   input  logic [NREQ-1:0][3:0]      req_be,
   input  logic [NREQ-1:0][N-1:0]    req_addr,
   input  logic [NREQ-1:0][N-1:0]    req_wdata,
   output logic [NREQ-1:0]           rsp_valid,
   output logic [N-1:0]              rsp_rdata,
   output logic                      mem_readEn,
   output logic                      mem_writeEn,
   output logic [N-1:0]              mem_address,
   output logic [N-1:0]              mem_datain,
   input  logic [N-1:0]              mem_dataout,
   output logic [1:0]                state_dbg
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXEC   = 2'd1;
   localparam logic [1:0] S_RMW_WR = 2'd2;

   logic [1:0]   state;
   logic         last_grant;
   logic         owner_q;
   logic         we_q;
   logic [3:0]   be_q;
   logic [N-1:0] addr_q;
   logic [N-1:0] wdata_q;
   logic [N-1:0] merge_q;

   logic         grant;
   logic         be_partial;
   logic         be_full;
   logic [N-1:0] be_mask;
   logic [1:0]   owner_onehot;

   assign state_dbg    = state;
   assign be_full      = (be_q == 4'hF);
   assign be_partial   = (be_q != 4'hF) && (be_q != 4'h0);
   assign owner_onehot = {owner_q, ~owner_q};

   // be[3] selects the most significant byte lane (byte offset 0, big-endian)
   assign be_mask = {{(N/4){be_q[3]}}, {(N/4){be_q[2]}},
                     {(N/4){be_q[1]}}, {(N/4){be_q[0]}}};

   // Arbitration: a lone requester wins; on a tie the policy decides
   always_comb begin
      grant = 1'b0;
      if (req_valid[0] && !req_valid[1]) begin
         grant = 1'b0;
      end else if (req_valid[1] && !req_valid[0]) begin
         grant = 1'b1;
      end else begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         grant = 1'b0;
`else
         grant = ~last_grant;
`endif
      end
   end

   // Accept strobe: only in IDLE, one-hot to the winner
   always_comb begin
      req_ready = '0;
      if ((state == S_IDLE) && (|req_valid)) begin
         req_ready[grant] = 1'b1;
      end
   end

   // DataMem controls decoded purely from the registered state
   always_comb begin
      mem_readEn  = 1'b0;
      mem_writeEn = 1'b0;
      mem_datain  = '0;
      mem_address = {addr_q[N-1:2], 2'b00};
      case (state)
         S_EXEC: begin
            if (!we_q || be_partial) begin
               mem_readEn = 1'b1;
            end else if (be_full) begin
               mem_writeEn = 1'b1;
               mem_datain  = wdata_q;
            end
         end
         S_RMW_WR: begin
            mem_writeEn = 1'b1;
            mem_datain  = merge_q;
         end
         default: begin
            mem_readEn  = 1'b0;
            mem_writeEn = 1'b0;
         end
      endcase
   end

   // Sequencer: latch the granted request, run the access, pulse the response
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= 4'h0;
         addr_q     <= '0;
         wdata_q    <= '0;
         merge_q    <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
      end else begin
         rsp_valid <= '0;
         case (state)
            S_IDLE: begin
               if (|req_valid) begin
                  owner_q    <= grant;
                  last_grant <= grant;
                  we_q       <= req_we[grant];
                  be_q       <= req_be[grant];
                  addr_q     <= req_addr[grant];
                  wdata_q    <= req_wdata[grant];
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!we_q) begin
                  rsp_rdata <= mem_dataout;
                  rsp_valid <= owner_onehot;
                  state     <= S_IDLE;
               end else if (be_partial) begin
                  // The other requester stays locked out until RMW_WR finishes
                  merge_q <= (mem_dataout & ~be_mask) | (wdata_q & be_mask);
                  state   <= S_RMW_WR;
               end else begin
                  // Full-word store or empty byte enable: single cycle, then ack
                  rsp_valid <= owner_onehot;
                  state     <= S_IDLE;
               end
            end
            S_RMW_WR: begin
               rsp_valid <= owner_onehot;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: bench for dmem_arbiter with a small DataMem stand-in, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, and a randomized two-requester phase.
// Honours DMEM_ARB_FIXED_PRIO_EN for the tie-break policy.
module tb_dmem_arbiter;

   logic             clk;
   logic             rstn;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_we;
   logic [1:0][3:0]  req_be;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       rsp_valid;
   logic [31:0]      rsp_rdata;
   logic             mem_readEn;
   logic             mem_writeEn;
   logic [31:0]      mem_address;
   logic [31:0]      mem_datain;
   logic [31:0]      mem_dataout;
   logic [1:0]       state_dbg;

   int n_checks;
   int n_fail;

   // backdoor preload port into the memory stand-in (and the model)
   logic        bd_we;
   logic [5:0]  bd_idx;
   logic [31:0] bd_val;

   logic [31:0] dmem    [64];
   logic [31:0] ref_mem [64];

   // model state: where the current transaction is on its timeline
   int          m_phase;   // 0 idle, 1 first access cycle, 2 write-back cycle
   logic        m_last;
   logic        m_owner;
   logic        m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_merge;
   logic [31:0] m_rdata;
   logic [1:0]  m_rsp_due;

   dmem_arbiter #(.N(32), .NREQ(2)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_be      (req_be),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .mem_readEn  (mem_readEn),
      .mem_writeEn (mem_writeEn),
      .mem_address (mem_address),
      .mem_datain  (mem_datain),
      .mem_dataout (mem_dataout),
      .state_dbg   (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DataMem stand-in: combinational read, write on posedge
   assign mem_dataout = dmem[mem_address[7:2]];
   always @(posedge clk) begin
      if (bd_we) dmem[bd_idx] <= bd_val;
      else if (mem_writeEn) dmem[mem_address[7:2]] <= mem_datain;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // tie-break rule from the requester's point of view
   function automatic logic pick(input logic [1:0] v, input logic last);
      if (v == 2'b01) return 1'b0;
      if (v == 2'b10) return 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~last;
`endif
   endfunction

   // byte-lane merge: be bit b owns data bits [8b+7:8b]
   function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // reference model + per-cycle compare, evaluated mid-cycle
   initial begin
      logic       g;
      logic [1:0] exp_ready;
      logic [1:0] next_rsp;
      logic       exp_re;
      logic       exp_wr;
      logic       part;
      int         wi;
      m_phase = 0; m_last = 1'b1; m_rsp_due = 2'b00; m_rdata = 32'h0;
      m_owner = 1'b0; m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0; m_merge = 32'h0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            chk("rst_ready", {30'h0, req_ready}, 32'h0);
            chk("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
            chk("rst_rdEn", {31'h0, mem_readEn}, 32'h0);
            chk("rst_wrEn", {31'h0, mem_writeEn}, 32'h0);
            m_phase = 0; m_last = 1'b1; m_rsp_due = 2'b00; m_rdata = 32'h0;
         end else begin
            g = pick(req_valid, m_last);
            exp_ready = 2'b00;
            if (m_phase == 0 && req_valid != 2'b00) exp_ready = g ? 2'b10 : 2'b01;
            part   = m_we && (m_be != 4'hF) && (m_be != 4'h0);
            exp_re = (m_phase == 1) && (!m_we || part);
            exp_wr = ((m_phase == 1) && m_we && (m_be == 4'hF)) || (m_phase == 2);
            chk("req_ready", {30'h0, req_ready}, {30'h0, exp_ready});
            chk("rsp_valid", {30'h0, rsp_valid}, {30'h0, m_rsp_due});
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("mem_readEn", {31'h0, mem_readEn}, {31'h0, exp_re});
            chk("mem_writeEn", {31'h0, mem_writeEn}, {31'h0, exp_wr});
            if (m_phase != 0) chk("mem_address", mem_address, {m_addr[31:2], 2'b00});
            if (exp_wr) chk("mem_datain", mem_datain, (m_phase == 2) ? m_merge : m_wdata);
            // advance the model across the coming posedge
            next_rsp = 2'b00;
            wi = int'(m_addr[7:2]);
            if (m_phase == 0) begin
               if (req_valid != 2'b00) begin
                  m_owner = g; m_last = g;
                  m_we = req_we[g]; m_be = req_be[g];
                  m_addr = req_addr[g]; m_wdata = req_wdata[g];
                  m_phase = 1;
               end
            end else if (m_phase == 1) begin
               if (!m_we) begin
                  m_rdata = ref_mem[wi];
                  next_rsp = m_owner ? 2'b10 : 2'b01;
                  m_phase = 0;
               end else if (part) begin
                  m_merge = merge_bytes(ref_mem[wi], m_wdata, m_be);
                  m_phase = 2;
               end else begin
                  if (m_be == 4'hF) ref_mem[wi] = m_wdata;
                  next_rsp = m_owner ? 2'b10 : 2'b01;
                  m_phase = 0;
               end
            end else begin
               ref_mem[wi] = m_merge;
               next_rsp = m_owner ? 2'b10 : 2'b01;
               m_phase = 0;
            end
            m_rsp_due = next_rsp;
         end
         if (bd_we) ref_mem[bd_idx] = bd_val;
      end
   end

   task automatic bd_write(input int idx, input logic [31:0] val);
      bd_idx = 6'(idx); bd_val = val; bd_we = 1'b1;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   // present one request and hold it until accepted; returns one cycle after accept
   task automatic issue(input int i, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
      int ok;
      req_we[i] = we; req_be[i] = be; req_addr[i] = addr; req_wdata[i] = wd;
      req_valid[i] = 1'b1;
      ok = 0;
      for (int c = 0; c < 50 && ok == 0; c++) begin
         @(negedge clk);
         if (req_ready[i]) ok = 1;
         @(posedge clk); #1;
      end
      req_valid[i] = 1'b0;
      chk("accept_in_time", ok, 1);
   endtask

   task automatic new_txn(input int i);
      int r;
      r = $urandom_range(0, 3);
      req_we[i]    = 1'($urandom_range(0, 1));
      req_be[i]    = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom_range(1, 14));
      req_addr[i]  = 32'($urandom_range(0, 255));
      req_wdata[i] = $urandom;
   endtask

   logic [1:0]  acc;
   logic        gr [4];
   logic [31:0] old_word;
   int          ng;

   // main sequence
   initial begin
      n_checks = 0; n_fail = 0;
      req_valid = 2'b00; req_we = 2'b00; req_be = '0; req_addr = '0; req_wdata = '0;
      bd_we = 1'b0; bd_idx = 6'h0; bd_val = 32'h0;
      rstn = 1'b1;
      #2 rstn = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 64; k++) bd_write(k, $urandom);
      chk("reset_state_idle", {30'h0, state_dbg}, 32'h0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk("reset_mem_address", mem_address, 32'h0);
      chk("reset_mem_datain", mem_datain, 32'h0);
      rstn = 1'b1;

      // idle for 10 cycles: model checks enables/ready/rsp each cycle
      repeat (10) begin @(posedge clk); #1; end
      chk("idle_no_enables", {30'h0, mem_readEn, mem_writeEn}, 32'h0);

      // full store then load of the same word through an unaligned address
      issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      @(posedge clk); #1;
      issue(0, 1'b0, 4'h0, 32'h13, 32'h0);
      @(posedge clk); #1;
      chk("load_rsp_valid_T2", {30'h0, rsp_valid}, 32'h1);
      chk("load_rdata_T2", rsp_rdata, 32'hDEADBEEF);

      // sub-word store from requester 1 as read-modify-write
      bd_write(8, 32'h11223344);
      issue(1, 1'b1, 4'b0100, 32'h20, 32'h00AA0000);
      chk("rmw_readEn_T1", {31'h0, mem_readEn}, 32'h1);
      @(posedge clk); #1;
      chk("rmw_writeEn_T2", {31'h0, mem_writeEn}, 32'h1);
      chk("rmw_readEn_off_T2", {31'h0, mem_readEn}, 32'h0);
      chk("rmw_datain_T2", mem_datain, 32'h11AA3344);
      @(posedge clk); #1;
      chk("rmw_rsp_T3", {30'h0, rsp_valid}, 32'h2);
      chk("rmw_mem_word", dmem[8], 32'h11AA3344);

      // both requesters continuously valid with loads
      req_we = 2'b00; req_be = '0;
      req_addr[0] = 32'h44; req_addr[1] = 32'h88;
      req_valid = 2'b11;
      ng = 0; acc = 2'b00;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         @(negedge clk);
         acc = req_ready & req_valid;
         if (acc != 2'b00) begin gr[ng] = acc[1]; ng++; end
         @(posedge clk); #1;
         if (acc[0]) req_addr[0] = 32'($urandom_range(0, 255));
         if (acc[1]) req_addr[1] = 32'($urandom_range(0, 255));
      end
      req_valid = req_valid & ~acc;
      for (int c = 0; c < 20 && req_valid != 2'b00; c++) begin
         @(negedge clk);
         acc = req_ready & req_valid;
         @(posedge clk); #1;
         req_valid = req_valid & ~acc;
      end
      chk("arb_grant_count", ng, 4);
      for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         chk($sformatf("arb_grant_%0d", k), {31'h0, gr[k]}, 32'h0);
`else
         chk($sformatf("arb_grant_%0d", k), {31'h0, gr[k]}, 32'(k % 2));
`endif
      end
      repeat (3) begin @(posedge clk); #1; end

      // empty byte-enable store: ack only, memory untouched
      old_word = dmem[32];
      issue(0, 1'b1, 4'h0, 32'h80, 32'hFFFFFFFF);
      chk("be0_no_access_T1", {30'h0, mem_readEn, mem_writeEn}, 32'h0);
      @(posedge clk); #1;
      chk("be0_rsp_T2", {30'h0, rsp_valid}, 32'h1);
      chk("be0_mem_unchanged", dmem[32], old_word);

      // reset while in the write-back cycle of a read-modify-write
      old_word = dmem[16];
      issue(0, 1'b1, 4'b0011, 32'h40, 32'h5A5A5A5A);
      @(posedge clk); #1;
      chk("pre_reset_writeEn", {31'h0, mem_writeEn}, 32'h1);
      rstn = 1'b0;
      #1;
      chk("reset_drops_writeEn", {31'h0, mem_writeEn}, 32'h0);
      chk("reset_state_idle2", {30'h0, state_dbg}, 32'h0);
      chk("reset_no_rsp", {30'h0, rsp_valid}, 32'h0);
      repeat (2) begin @(posedge clk); #1; end
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("reset_mem_unchanged", dmem[16], old_word);

      // randomized traffic from both requesters
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         acc = req_ready & req_valid;
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (acc[i] || !req_valid[i]) begin
               if ($urandom_range(0, 2) != 0) begin
                  new_txn(i);
                  req_valid[i] = 1'b1;
               end else begin
                  req_valid[i] = 1'b0;
               end
            end
         end
      end
      for (int c = 0; c < 20 && req_valid != 2'b00; c++) begin
         @(negedge clk);
         acc = req_ready & req_valid;
         @(posedge clk); #1;
         req_valid = req_valid & ~acc;
      end
      chk("drain_complete", {30'h0, req_valid}, 32'h0);
      repeat (4) begin @(posedge clk); #1; end
      for (int k = 0; k < 64; k++) chk($sformatf("final_mem_%0d", k), dmem[k], ref_mem[k]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
